pc_gen: RTL and testbench

- Parametrised fetch program-counter generator; successor to the plain PC register / +4 incrementer / branch-target adder trio.
- Holds the fetch PC and presents it to fetch over a valid/ready handshake.
- Applies trap and branch redirects by priority, with misalignment detection and a halt mode.
- Sits between decode/execute redirect logic and the instruction-fetch stage.

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_gen.sv | 128 ++++++++++++
 tb/tb_pc_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: width, vector defaults and
// the fetch-state encoding.
package pc_gen_pkg;

  localparam int unsigned WORDSIZE_DEF     = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam int unsigned RAS_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and the count saturates at DEPTH. DEPTH must be a power of two, at least 2.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WORDSIZE_DEF,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // ptr_q is the next free slot; it wraps naturally because DEPTH is a power of two.
  assign top   = mem_q[ptr_q - PTR_W'(1)];
  assign empty = (cnt_q == '0);

  // A simultaneous push and pop replaces the top entry in place.
  assign wr_idx = pop ? (ptr_q - PTR_W'(1)) : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push && !pop) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push && cnt_q != '0) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; entries are
  // only ever read below a valid count, so their power-up value never leaks.
  always_ff @(posedge CLK) begin
    if (push && !clear) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/branch redirect, halt mode and
// misalignment detection. Define PCGEN_RAS_EN to add a return-address stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          WORDSIZE     = WORDSIZE_DEF,
  parameter int unsigned          INSN_BYTES   = 4,
  parameter logic [WORDSIZE-1:0]  RESET_VECTOR = WORDSIZE'(RESET_VECTOR_DEF),
  parameter logic [WORDSIZE-1:0]  TRAP_VECTOR  = WORDSIZE'(TRAP_VECTOR_DEF),
  parameter int unsigned          RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  output logic [WORDSIZE-1:0] pc_out,
  output logic                pc_valid,
  input  logic                fetch_ready,
  output logic [WORDSIZE-1:0] link_addr,
  input  logic                br_taken,
  input  logic [WORDSIZE-1:0] br_base,
  input  logic [WORDSIZE-1:0] br_offset,
  input  logic                br_is_call,
  input  logic                br_is_ret,
  input  logic                trap_req,
  input  logic                halt,
  output logic [WORDSIZE-1:0] epc,
  output logic                misalign
);

  localparam int unsigned OFF_BITS = $clog2(INSN_BYTES);

  pc_state_e           state_q, state_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [WORDSIZE-1:0] epc_q, epc_d;
  logic                misalign_q, misalign_d;
  logic [WORDSIZE-1:0] br_tgt;
  logic                active;
  logic                tgt_misaligned;

  // Redirects are honoured in RUN and HALT, never in BOOT.
  assign active    = (state_q != ST_BOOT);
  assign pc_valid  = (state_q == ST_RUN);
  assign link_addr = pc_q + WORDSIZE'(INSN_BYTES);

`ifdef PCGEN_RAS_EN
  logic                ras_push, ras_pop, ras_clear, ras_empty;
  logic [WORDSIZE-1:0] ras_top;

  assign ras_clear = active & trap_req;
  assign ras_push  = active & br_taken & br_is_call & ~trap_req;
  assign ras_pop   = active & br_taken & br_is_ret & ~trap_req & ~ras_empty;

  pc_ras #(
    .WIDTH (WORDSIZE),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (ras_clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign br_tgt = ras_pop ? ras_top : (br_base + br_offset);
`else
  logic ras_unused;
  assign ras_unused = br_is_call ^ br_is_ret;
  assign br_tgt     = br_base + br_offset;
`endif

  assign tgt_misaligned = |br_tgt[OFF_BITS-1:0];

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = halt ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt && !trap_req && !br_taken) state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (active) begin
      if (trap_req) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
      end else if (br_taken) begin
        if (tgt_misaligned) begin
          pc_d       = TRAP_VECTOR;
          epc_d      = pc_q;
          misalign_d = 1'b1;
        end else begin
          pc_d = br_tgt;
        end
      end else if (pc_valid && fetch_ready) begin
        pc_d = link_addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its peers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out   = pc_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a behavioural model (the stack model is active under PCGEN_RAS_EN).
module tb_pc_gen;

  localparam logic [31:0] RESET_V = 32'h0;
  localparam logic [31:0] TRAP_V  = 32'h100;
  localparam int unsigned INSN    = 4;
  localparam int unsigned DEPTH   = 4;

  logic        CLK = 1'b0;
  logic        reset, fetch_ready, br_taken, br_is_call, br_is_ret, trap_req, halt;
  logic [31:0] br_base, br_offset;
  logic [31:0] pc_out, link_addr, epc;
  logic        pc_valid, misalign;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model state.
  logic [31:0] m_pc, m_epc;
  bit          m_mis, m_boot, m_halted;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .CLK         (CLK),
    .reset       (reset),
    .pc_out      (pc_out),
    .pc_valid    (pc_valid),
    .fetch_ready (fetch_ready),
    .link_addr   (link_addr),
    .br_taken    (br_taken),
    .br_base     (br_base),
    .br_offset   (br_offset),
    .br_is_call  (br_is_call),
    .br_is_ret   (br_is_ret),
    .trap_req    (trap_req),
    .halt        (halt),
    .epc         (epc),
    .misalign    (misalign)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_in(input bit rst, input bit hlt, input bit rdy, input bit bt,
                        input bit call, input bit ret, input bit trp,
                        input logic [31:0] base, input logic [31:0] off);
    reset = rst; halt = hlt; fetch_ready = rdy; br_taken = bt;
    br_is_call = call; br_is_ret = ret; trap_req = trp;
    br_base = base; br_offset = off;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] link, tgt;
    bit          was_halted;
    if (reset) begin
      m_pc = RESET_V; m_epc = '0; m_mis = 0; m_boot = 1; m_halted = 0;
      m_ras.delete();
    end else if (m_boot) begin
      m_boot = 0; m_halted = halt; m_mis = 0;
    end else begin
      link       = m_pc + INSN;
      was_halted = m_halted;
      m_mis      = 0;
      if (trap_req) begin
        m_epc = m_pc; m_pc = TRAP_V;
        m_ras.delete();
      end else if (br_taken) begin
        tgt = br_base + br_offset;
`ifdef PCGEN_RAS_EN
        if (br_is_ret && m_ras.size() > 0) tgt = m_ras.pop_back();
        if (br_is_call) begin
          m_ras.push_back(link);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        if (tgt % INSN != 0) begin
          m_epc = m_pc; m_pc = TRAP_V; m_mis = 1;
        end else begin
          m_pc = tgt;
        end
      end else if (!was_halted && fetch_ready) begin
        m_pc = link;
      end
      if (!was_halted) m_halted = halt && !trap_req && !br_taken;
      else             m_halted = halt;
    end
  endtask

  task automatic check_outputs();
    check("pc_out",    pc_out,           m_pc);
    check("pc_valid",  32'(pc_valid),    32'(!m_boot && !m_halted));
    check("epc",       epc,              m_epc);
    check("misalign",  32'(misalign),    32'(m_mis));
    check("link_addr", link_addr,        m_pc + INSN);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  initial begin
    // Reset overrides an active halt, redirect and trap.
    set_in(1, 1, 1, 1, 0, 0, 1, 32'h40, 32'h0);
    tick(); tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("boot_pc", pc_out, 32'h0);
    check("boot_valid", 32'(pc_valid), 32'd0);
    tick(); check("seq0", pc_out, 32'h0); check("seq0_valid", 32'(pc_valid), 32'd1);
    tick(); check("seq4", pc_out, 32'h4);
    tick(); check("seq8", pc_out, 32'h8);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) begin tick(); check("stall", pc_out, 32'h8); end
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tick(); check("resume", pc_out, 32'hC);

    // Negative offset wraps; odd offset traps.
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h40, 32'hFFFF_FFF0);
    tick(); check("br_neg", pc_out, 32'h30);
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h40, 32'h2);
    tick(); check("mis_pc", pc_out, 32'h100);
    check("mis_pulse", 32'(misalign), 32'd1); check("mis_epc", epc, 32'h30);
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tick(); check("mis_clear", 32'(misalign), 32'd0);

    // Trap wins over a simultaneous branch.
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h20, 32'h0);
    tick(); check("br_20", pc_out, 32'h20);
    set_in(0, 0, 1, 1, 0, 0, 1, 32'h500, 32'h0);
    tick(); check("trap_pc", pc_out, 32'h100); check("trap_epc", epc, 32'h20);

    // Halt, redirect while halted, release.
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h10, 32'h0);
    tick(); check("br_10", pc_out, 32'h10);
    set_in(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tick(); check("halt_valid", 32'(pc_valid), 32'd0); check("halt_pc", pc_out, 32'h14);
    set_in(0, 1, 1, 1, 0, 0, 0, 32'h80, 32'h0);
    tick(); check("halt_br", pc_out, 32'h80); check("halt_br_valid", 32'(pc_valid), 32'd0);
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    tick(); check("unhalt_pc", pc_out, 32'h80); check("unhalt_valid", 32'(pc_valid), 32'd1);

`ifdef PCGEN_RAS_EN
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0); tick(); tick();
    set_in(0, 0, 0, 1, 0, 0, 0, 32'h10, 32'h0); tick();
    set_in(0, 0, 0, 1, 1, 0, 0, 32'h200, 32'h0);
    tick(); check("call_pc", pc_out, 32'h200);
    set_in(0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0);
    tick(); check("ret_pc", pc_out, 32'h14);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1, 1, 0, 0, 32'h300 + 32'(i) * 32'h100, 32'h0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_ret;
      exp_ret = (i < 4) ? (32'h604 - 32'(i) * 32'h100) : 32'h900;
      set_in(0, 0, 0, 1, 0, 1, 0, 32'h900, 32'h0);
      tick(); check("ras_ret", pc_out, exp_ret);
    end
`endif

    // Randomized traffic against the model.
    begin
      bit hold_halt = 0;
      for (int i = 0; i < 3000; i++) begin
        bit          r_rst, r_bt, r_call, r_ret;
        int unsigned sel;
        logic [31:0] off;
        r_rst = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 9) == 0) hold_halt = !hold_halt;
        r_bt  = ($urandom_range(0, 5) == 0);
        sel   = $urandom_range(0, 3);
        r_call = (sel == 1);
        r_ret  = (sel == 2);
        off = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        set_in(r_rst, hold_halt, ($urandom_range(0, 3) != 0), r_bt, r_call, r_ret,
               ($urandom_range(0, 19) == 0), $urandom & 32'h0000_0FFC, off);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
